// File: rtl/add_arb_pkg.sv
// Shared constants, requester id type and round-robin pick helper for the
// adder request arbiter.
package add_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_OUTST_DEF = 4;
  localparam int MAX_REQ       = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  // One-hot winner: first set bit of valid searching ptr, ptr+1, ... wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input req_id_t ptr,
                                                 input int n);
    int   idx;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx]) begin
          rr_pick[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/add_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding adder operations.
// A push is accepted while full when a pop happens in the same cycle.
module add_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_CNT);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = mem_q[rdPtr_q];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/add_req_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters; results come
// back in issue order and are steered to their requester via a tag FIFO.
module add_req_arbiter
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        add_valid,
  input  logic                        add_ready,
  output logic [DATA_W-1:0]           add_a,
  output logic [DATA_W-1:0]           add_b,
  input  logic                        add_res_valid,
  input  logic [DATA_W:0]             add_res,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W:0]             rsp_sum,
  output logic [$clog2(MAX_OUTST):0]  outstanding,
  output logic                        busy,
  output logic                        err_unexp
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] rspValid_q, rspValid_d;
  logic [DATA_W:0]    rspSum_q, rspSum_d;
  logic               errUnexp_q, errUnexp_d;

  logic [MAX_REQ-1:0] validPad, pickPad;
  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    winner, fifoHead;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoFull, fifoEmpty, canIssue, fire, pop;

  // A result popping this cycle frees a slot, so a full FIFO can still issue.
  assign pop      = add_res_valid & ~fifoEmpty;
  assign canIssue = enable & add_ready & (~fifoFull | pop);
  assign fire     = add_valid & add_ready;

  always_comb begin
    validPad                = '0;
    validPad[NUM_REQ-1:0]   = req_valid;
    pickPad                 = rr_pick(validPad, req_id_t'(rrPtr_q), NUM_REQ);
    pick                    = pickPad[NUM_REQ-1:0];
  end

  always_comb begin
    winner    = '0;
    add_a     = '0;
    add_b     = '0;
    req_ready = canIssue ? pick : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) winner = ID_W'(i);
      if (req_ready[i]) begin
        add_a = req_a[i*DATA_W +: DATA_W];
        add_b = req_b[i*DATA_W +: DATA_W];
      end
    end
    add_valid = |req_ready;
  end

  always_comb begin
    rrPtr_d    = rrPtr_q;
    rspValid_d = '0;
    rspSum_d   = rspSum_q;
    errUnexp_d = errUnexp_q | (add_res_valid & fifoEmpty);
    if (fire) rrPtr_d = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    if (pop) begin
      rspValid_d[fifoHead] = 1'b1;
      rspSum_d             = add_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q    <= '0;
      rspValid_q <= '0;
      rspSum_q   <= '0;
      errUnexp_q <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      rspValid_q <= rspValid_d;
      rspSum_q   <= rspSum_d;
      errUnexp_q <= errUnexp_d;
    end
  end

  add_arb_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (winner),
    .pop       (pop),
    .head      (fifoHead),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .count     (fifoCount)
  );

  assign rsp_valid   = rspValid_q;
  assign rsp_sum     = rspSum_q;
  assign outstanding = fifoCount;
  assign busy        = (fifoCount != '0);
  assign err_unexp   = errUnexp_q;

endmodule

// File: tb/tb_add_req_arbiter.sv
// Directed bench for add_req_arbiter with a fixed-latency adder model and a
// scoreboard of expected (requester, sum) pairs in issue order.
module tb_add_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        add_valid, add_ready;
  logic [7:0]  add_a, add_b;
  logic        add_res_valid;
  logic [8:0]  add_res;
  logic [3:0]  rsp_valid;
  logic [8:0]  rsp_sum;
  logic [2:0]  outstanding;
  logic        busy, err_unexp;

  logic [7:0]  opA [4];
  logic [7:0]  opB [4];
  int          lat;
  logic        modelValid, injectValid;
  logic [8:0]  modelRes, injectRes;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [8:0] sum; int due; } pipeEntry_t;
  typedef struct { int id; logic [8:0] sum; } sbEntry_t;
  pipeEntry_t pipe[$];
  sbEntry_t   sb[$];
  int         cyc = 0;

  int         expPtr;
  bit         rspDue, expErr;
  int         rspId;
  logic [8:0] rspSum;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = opA[i];
      req_b[i*8 +: 8] = opB[i];
    end
  end

  assign add_res_valid = modelValid | injectValid;
  assign add_res       = modelValid ? modelRes : injectRes;

  add_req_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .add_valid     (add_valid),
    .add_ready     (add_ready),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_res_valid (add_res_valid),
    .add_res       (add_res),
    .rsp_valid     (rsp_valid),
    .rsp_sum       (rsp_sum),
    .outstanding   (outstanding),
    .busy          (busy),
    .err_unexp     (err_unexp)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic en, input logic rdy);
    req_valid = v;
    enable    = en;
    add_ready = rdy;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    injectValid = 1'b0;
    stepCycles(2);
    rst_n = 1'b1;
  endtask

  // Fixed-latency adder: an operation issued in cycle c returns in cycle c+lat.
  always @(posedge clk) begin
    if (!rst_n) pipe.delete();
    else if (add_valid && add_ready)
      pipe.push_back('{sum: {1'b0, add_a} + {1'b0, add_b}, due: cyc + lat});
    cyc++;
    #1;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      modelValid = 1'b1;
      modelRes   = pipe[0].sum;
      void'(pipe.pop_front());
    end else begin
      modelValid = 1'b0;
      modelRes   = '0;
    end
  end

  // Reference model of grants, occupancy and result routing, checked every cycle.
  always @(negedge clk) begin
    logic [3:0] expReady;
    logic       popM, canM;
    bit         found;
    int         win, j;
    if (!rst_n) begin
      expPtr = 0;
      sb.delete();
      rspDue = 1'b0;
      expErr = 1'b0;
      checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_sum", 32'(rsp_sum), 32'd0);
      checkOutput("rst_err_unexp", 32'(err_unexp), 32'd0);
    end else begin
      popM  = add_res_valid && (sb.size() > 0);
      canM  = enable && add_ready && ((sb.size() < 4) || popM);
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < 4; k++) begin
        j = (expPtr + k) % 4;
        if (!found && req_valid[j]) begin
          found = 1'b1;
          win   = j;
        end
      end
      expReady = (canM && found) ? 4'(1 << win) : 4'b0000;

      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("add_valid", 32'(add_valid), 32'(|expReady));
      checkOutput("add_a", 32'(add_a), (|expReady) ? 32'(opA[win]) : 32'd0);
      checkOutput("add_b", 32'(add_b), (|expReady) ? 32'(opB[win]) : 32'd0);
      checkOutput("outstanding", 32'(outstanding), 32'(sb.size()));
      checkOutput("busy", 32'(busy), 32'(sb.size() != 0));
      checkOutput("err_unexp", 32'(err_unexp), 32'(expErr));
      checkOutput("rsp_valid", 32'(rsp_valid), rspDue ? 32'(1 << rspId) : 32'd0);
      if (rspDue) checkOutput("rsp_sum", 32'(rsp_sum), 32'(rspSum));

      rspDue = 1'b0;
      if (popM) begin
        sbEntry_t e;
        e      = sb.pop_front();
        rspDue = 1'b1;
        rspId  = e.id;
        rspSum = e.sum;
      end else if (add_res_valid) begin
        expErr = 1'b1;
      end
      if (|expReady) begin
        sb.push_back('{id: win, sum: {1'b0, opA[win]} + {1'b0, opB[win]}});
        expPtr = (win + 1) % 4;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    injectValid = 1'b0;
    injectRes   = '0;
    lat         = 3;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    // Single requester 2, latency 3: response four cycles after issue.
    doReset();
    opA[2] = 8'h7F;
    opB[2] = 8'h01;
    applyStimulus(4'b0100, 1'b1, 1'b1);
    #1 checkOutput("t1_grant", 32'(req_ready), 32'h4);
    stepCycles(1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycles(3);
    #1;
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h4);
    checkOutput("t1_rsp_sum", 32'(rsp_sum), 32'h080);
    stepCycles(3);

    // All requesters continuously valid: grants rotate 0,1,2,3,...
    doReset();
    for (int i = 0; i < 4; i++) begin
      opA[i] = 8'(i);
      opB[i] = 8'(16 * i);
    end
    applyStimulus(4'b1111, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1 checkOutput("t2_grant_order", 32'(req_ready), 32'(1 << (k % 4)));
      stepCycles(1);
    end
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycles(8);

    // Adder not ready for 5 cycles: no grants, then order resumes at 0.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("t3_stall_ready", 32'(req_ready), 32'h0);
      checkOutput("t3_stall_valid", 32'(add_valid), 32'h0);
      stepCycles(1);
    end
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #1 checkOutput("t3_resume0", 32'(req_ready), 32'h1);
    stepCycles(1);
    #1 checkOutput("t3_resume1", 32'(req_ready), 32'h2);
    stepCycles(1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycles(6);

    // Enable dropped with two operations in flight: results still route back.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    stepCycles(2);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    #1 checkOutput("t4_disabled", 32'(req_ready), 32'h0);
    stepCycles(2);
    #1;
    checkOutput("t4_rsp2_valid", 32'(rsp_valid), 32'h4);
    checkOutput("t4_rsp2_sum", 32'(rsp_sum), 32'h022);
    stepCycles(1);
    #1;
    checkOutput("t4_rsp3_valid", 32'(rsp_valid), 32'h8);
    checkOutput("t4_rsp3_sum", 32'(rsp_sum), 32'h033);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycles(4);

    // Latency 8: FIFO fills at 4, fifth issue accepted alongside the first pop.
    lat    = 8;
    opA[3] = 8'hFF;
    opB[3] = 8'hFF;
    applyStimulus(4'b1111, 1'b1, 1'b1);
    stepCycles(4);
    #1;
    checkOutput("t5_full_count", 32'(outstanding), 32'd4);
    checkOutput("t5_full_nogrant", 32'(req_ready), 32'h0);
    stepCycles(4);
    #1;
    checkOutput("t5_pop_push_grant", 32'(req_ready), 32'h1);
    checkOutput("t5_pop_push_count", 32'(outstanding), 32'd4);
    stepCycles(1);
    #1 checkOutput("t5_count_after", 32'(outstanding), 32'd4);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycles(12);

    // Result with nothing outstanding: sticky error, no response.
    injectRes   = 9'h1AA;
    injectValid = 1'b1;
    stepCycles(1);
    injectValid = 1'b0;
    #1;
    checkOutput("t6_err_set", 32'(err_unexp), 32'd1);
    checkOutput("t6_no_rsp", 32'(rsp_valid), 32'h0);
    stepCycles(3);
    #1 checkOutput("t6_err_sticky", 32'(err_unexp), 32'd1);

    // Reset mid-operation with 3 outstanding clears state asynchronously.
    applyStimulus(4'b0010, 1'b1, 1'b1);
    stepCycles(3);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    #1 checkOutput("t7_pre_outst", 32'(outstanding), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_async_outst", 32'(outstanding), 32'd0);
    checkOutput("t7_async_busy", 32'(busy), 32'd0);
    checkOutput("t7_async_rsp", 32'(rsp_valid), 32'h0);
    checkOutput("t7_async_err", 32'(err_unexp), 32'd0);
    stepCycles(2);
    rst_n = 1'b1;
    lat   = 3;
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #1 checkOutput("t7_first_grant", 32'(req_ready), 32'h1);
    stepCycles(1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycles(8);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
